// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, one bit per clock, LSB first.
// A single borrow flip-flop stands in for the ripple borrow chain.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_d;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  // One full-subtractor cell operating on the current LSBs of the operand shifters
  assign w_d          = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
  assign w_res_nxt    = {w_d, r_res[WIDTH-1:1]};
  assign w_last       = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_borrow   <= 1'b0;
      r_cnt      <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      DIFF       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_a_msb  <= A[WIDTH-1];
            r_b_msb  <= B[WIDTH-1];
            r_res    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrow_nxt;
          r_res    <= w_res_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            // Results are published only here so partial sums never reach DIFF
            busy       <= 1'b0;
            done       <= 1'b1;
            DIFF       <= w_res_nxt;
            borrow_out <= w_borrow_nxt;
            overflow   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
            r_state    <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         busy, done, borrow_out, overflow;
  logic [W-1:0] DIFF;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .DIFF(DIFF), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void ref_sub(input int a, input int b, input int bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
    int r, sa, sb, sr;
    r  = a - b - bin;
    if (r < 0) r = r + (1 << W);
    d  = r[W-1:0];
    bo = (a < b + bin);
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sr = sa - sb - bin;
    ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
  endfunction

  // Runs one operation from IDLE and checks cycle-exact handshake and results
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input string tag);
    logic [W-1:0] ed, prev;
    logic eb, eo;
    ref_sub(int'(a), int'(b), int'(bin), ed, eb, eo);
    prev = DIFF;
    A = a; B = b; Bin = bin; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      total++;
      if ({busy, done} !== 2'b10) begin
        bad++; $display("FAIL %s shift%0d busy/done got=%b%b want=10", tag, k, busy, done);
      end
      total++;
      if (DIFF !== prev) begin
        bad++; $display("FAIL %s shift%0d DIFF changed got=%h want=%h", tag, k, DIFF, prev);
      end
      tick();
    end
    total++;
    if ({busy, done} !== 2'b01) begin
      bad++; $display("FAIL %s done-cycle busy/done got=%b%b want=01", tag, busy, done);
    end
    total++;
    if ({DIFF, borrow_out, overflow} !== {ed, eb, eo}) begin
      bad++; $display("FAIL %s a=%h b=%h bin=%b DIFF/bo/ov got=%h/%b/%b want=%h/%b/%b",
                      tag, a, b, bin, DIFF, borrow_out, overflow, ed, eb, eo);
    end
    tick();
    total++;
    if ({busy, done, DIFF, borrow_out, overflow} !== {2'b00, ed, eb, eo}) begin
      bad++; $display("FAIL %s hold busy/done/DIFF/bo/ov got=%b%b/%h/%b/%b want=00/%h/%b/%b",
                      tag, busy, done, DIFF, borrow_out, overflow, ed, eb, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #2;
    total++;
    if ({busy, done, DIFF, borrow_out, overflow} !== '0) begin
      bad++; $display("FAIL reset outputs got=%b%b/%h/%b/%b want=all 0", busy, done, DIFF, borrow_out, overflow);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL reset idle busy/done got=%b%b want=00", busy, done);
    end
  endtask

  task automatic test_directed();
    do_op(4'd9, 4'd3, 1'b0, "dir_9_3");
    do_op(4'd3, 4'd9, 1'b0, "dir_3_9");
    do_op(4'd0, 4'd0, 1'b1, "dir_0_0_bin");
    do_op(4'd8, 4'd1, 1'b0, "dir_8_1");
    do_op(4'd7, 4'd8, 1'b1, "dir_7_8_bin");
  endtask

  task automatic test_ignore_start();
    A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
    tick();
    for (int k = 1; k <= W; k++) begin
      start = k[0]; A = 4'hF; B = 4'h0; Bin = 1'b1;
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL ignore shift%0d busy got=%b want=1", k, busy);
      end
      tick();
    end
    start = 1'b1;
    total++;
    if ({done, DIFF} !== {1'b1, 4'd3}) begin
      bad++; $display("FAIL ignore done/DIFF got=%b/%h want=1/3", done, DIFF);
    end
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({busy, done} !== 2'b00) begin
        bad++; $display("FAIL ignore idle%0d busy/done got=%b%b want=00", k, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      total++;
      if (done !== ((c % 6) == 4)) begin
        bad++; $display("FAIL b2b cycle%0d done got=%b want=%b", c, done, (c % 6) == 4);
      end
      total++;
      if (busy !== ((c % 6) < 4)) begin
        bad++; $display("FAIL b2b cycle%0d busy got=%b want=%b", c, busy, (c % 6) < 4);
      end
      if (done === 1'b1) begin
        ndone++;
        total++;
        if (DIFF !== 4'd3) begin
          bad++; $display("FAIL b2b cycle%0d DIFF got=%h want=3", c, DIFF);
        end
      end
      start = (c + 1 <= 19);
      if (((c + 1) % 6) >= 1 && ((c + 1) % 6) <= 4) begin
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end else begin
        A = 4'd5; B = 4'd2; Bin = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 4) begin
      bad++; $display("FAIL b2b done count got=%0d want=4", ndone);
    end
  endtask

  task automatic test_reset_mid();
    A = 4'd7; B = 4'd1; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, DIFF, borrow_out, overflow} !== '0) begin
      bad++; $display("FAIL rstmid async outputs got=%b%b/%h/%b/%b want=all 0", busy, done, DIFF, borrow_out, overflow);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({busy, done, DIFF} !== '0) begin
        bad++; $display("FAIL rstmid after%0d busy/done/DIFF got=%b%b/%h want=00/0", k, busy, done, DIFF);
      end
      tick();
    end
    do_op(4'd15, 4'd15, 1'b0, "rstmid_15_15");
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
